priority_encoder_8to3: RTL and testbench

//   Registered 8-to-3 priority encoder. Reports the index of the highest-priority

---
 rtl/priority_encoder_8to3_if.sv | 13 +
 rtl/priority_encoder_8to3.sv | 49 ++++
 tb/tb_priority_encoder_8to3.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/priority_encoder_8to3_if.sv
// Request/result bundle for the 8-to-3 priority encoder.
// Carries the request vector d and the registered result e/v; no flow control.
// The requester drives d every cycle and the encoder answers one cycle later.
interface priority_encoder_8to3_if;
  logic [7:0] d;  // request vector, bit i = request i
  logic [2:0] e;  // index of the winning request
  logic       v;  // any request was present

  // Requester side: drives requests, observes the encoded result.
  modport master (output d, input e, v);
  // Encoder side: samples requests, drives the encoded result.
  modport slave  (input d, output e, v);
endinterface

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder: index of the winning request bit plus any-valid.
// Latency: exactly one clock from sampled d to e/v.
// Backpressure: none; a new request vector is accepted every cycle.
module priority_encoder_8to3 #(
  parameter bit LSB_PRIORITY = 1'b0  // 0: d[7] wins, 1: d[0] wins
) (
  input  logic                  clk,
  input  logic                  rst,
  priority_encoder_8to3_if.slave bus
);

  logic [2:0] enc;
  logic       any;
  logic [2:0] e_q;
  logic       v_q;

  // Pick the winning index: the scan order makes the highest-priority set bit
  // the last assignment. No set bit leaves the index at 0, so e is never X.
  always_comb begin
    enc = 3'b000;
    if (LSB_PRIORITY) begin
      for (int i = 7; i >= 0; i--) begin
        if (bus.d[i]) enc = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus.d[i]) enc = 3'(i);
      end
    end
  end

  assign any = |bus.d;

  // Output register; reset wins over the sampled request and forces 0/0.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= 3'b000;
      v_q <= 1'b0;
    end else begin
      e_q <= enc;
      v_q <= any;
    end
  end

  // Outputs come straight from flops: no combinational path from d.
  assign bus.e = e_q;
  assign bus.v = v_q;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
module tb_priority_encoder_8to3;

  logic clk;
  logic rst;

  priority_encoder_8to3_if bus_msb ();
  priority_encoder_8to3_if bus_lsb ();

  priority_encoder_8to3 #(.LSB_PRIORITY(1'b0)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_msb)
  );

  priority_encoder_8to3 #(.LSB_PRIORITY(1'b1)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       r;
    logic [2:0] e;
    logic       v;
  } exp_t;

  exp_t q_msb[$];
  exp_t q_lsb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: highest set bit is floor(log2(d)); lowest set bit is log2 of
  // the isolated lowest one (d & -d). Zero input gives 0/0.
  function automatic exp_t model(input logic [7:0] x, input logic r, input bit lsb);
    exp_t t;
    int   n;
    int   idx;
    n   = int'(x);
    t.d = x;
    t.r = r;
    if (r || n == 0) begin
      t.e = 3'd0;
      t.v = 1'b0;
    end else begin
      if (lsb) idx = $clog2(n & -n);
      else     idx = $clog2(n + 1) - 1;
      t.e = idx[2:0];
      t.v = 1'b1;
    end
    return t;
  endfunction

  // Present one request vector for the next rising edge and record the
  // expected response for both priority orders.
  task automatic step(input logic r, input logic [7:0] val);
    rst       = r;
    bus_msb.d = val;
    bus_lsb.d = val;
    q_msb.push_back(model(val, r, 1'b0));
    q_lsb.push_back(model(val, r, 1'b1));
    @(negedge clk);
  endtask

  // Monitor: every edge yields a result one cycle after its stimulus.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q_msb.size() > 0) begin
        x = q_msb.pop_front();
        checks++;
        if (bus_msb.e !== x.e || bus_msb.v !== x.v) begin
          errors++;
          $display("FAIL msb_enc d=%02h rst=%0b got e=%0d v=%0b want e=%0d v=%0b",
                   x.d, x.r, bus_msb.e, bus_msb.v, x.e, x.v);
        end
      end
      if (q_lsb.size() > 0) begin
        x = q_lsb.pop_front();
        checks++;
        if (bus_lsb.e !== x.e || bus_lsb.v !== x.v) begin
          errors++;
          $display("FAIL lsb_enc d=%02h rst=%0b got e=%0d v=%0b want e=%0d v=%0b",
                   x.d, x.r, bus_lsb.e, bus_lsb.v, x.e, x.v);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, got timeout want completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    logic [7:0] dv;
    // Reset held two cycles with all requests set, then release.
    step(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    step(1'b0, 8'hFF);
    // Zero input.
    step(1'b0, 8'h00);
    // One-hot walk.
    for (int i = 0; i < 8; i++) begin
      dv = 8'h01 << i;
      step(1'b0, dv);
    end
    // Priority patterns.
    step(1'b0, 8'hFF);
    step(1'b0, 8'h0C);
    step(1'b0, 8'h41);
    // Exhaustive sweep with a one-cycle reset at 8'h90.
    for (int i = 0; i < 256; i++) begin
      dv = 8'(i);
      step(dv == 8'h90, dv);
    end
    // Randomized requests with occasional resets.
    for (int i = 0; i < 300; i++) begin
      dv = 8'($urandom_range(0, 255));
      step($urandom_range(0, 19) == 0, dv);
    end
    step(1'b0, 8'h00);
    // Let the monitor drain, then confirm every expectation was consumed.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q_msb.size() != 0 || q_lsb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", q_msb.size(), q_lsb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
